// File: rtl/accel_pkg.sv
// Shared types and default widths for the accumulator datapath.
package accel_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int ACC_WIDTH_DEF  = 20;
  localparam int CNT_WIDTH_DEF  = 8;

  // Default-width signed accumulator; modules re-declare at their own width.
  typedef logic signed [ACC_WIDTH_DEF-1:0] acc_t;

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } acc_state_e;

endpackage

// File: rtl/full_adder.sv
// Single-bit full adder cell.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/ripple_carry_adder.sv
// Ripple-carry adder; also exposes the carry into the MSB for signed overflow.
module ripple_carry_adder #(
  parameter int WIDTH = 20
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic [WIDTH-1:0] sum,
  output logic             carry_msb_in,
  output logic             carry_out
);

  logic [WIDTH:0] c;

  assign c[0] = carry_in;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    full_adder u_fa (
      .a    (a[i]),
      .b    (b[i]),
      .cin  (c[i]),
      .s    (sum[i]),
      .cout (c[i+1])
    );
  end

  assign carry_msb_in = c[WIDTH-1];
  assign carry_out    = c[WIDTH];

endmodule

// File: rtl/stream_accumulator.sv
// Packet accumulator: sums signed beats, emits sum/count/overflow per packet.
module stream_accumulator
  import accel_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH  = ACC_WIDTH_DEF,
  parameter int CNT_WIDTH  = CNT_WIDTH_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_last,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [ACC_WIDTH-1:0]  out_data,
  output logic [CNT_WIDTH-1:0]  out_count,
  output logic                  out_ovf
);

  typedef logic signed [ACC_WIDTH-1:0] sacc_t;

  acc_state_e            state_q, state_d;
  sacc_t                 acc_q, acc_d;
  sacc_t                 out_data_q, out_data_d;
  logic [CNT_WIDTH-1:0]  cnt_q, cnt_d, out_cnt_q, out_cnt_d, cnt_inc;
  logic                  ovf_q, ovf_d, out_ovf_q, out_ovf_d;

  sacc_t                 operand;
  logic [ACC_WIDTH-1:0]  sum;
  logic                  c_msb_in, c_out, beat_ovf;
  logic                  fire_in, fire_out;

  assign out_valid = (state_q == HOLD);
  // Result slot frees up in the same cycle it drains, so packets pipeline.
  assign in_ready  = !out_valid || out_ready;
  assign fire_in   = in_valid && in_ready;
  assign fire_out  = out_valid && out_ready;

  assign out_data  = out_data_q;
  assign out_count = out_cnt_q;
  assign out_ovf   = out_ovf_q;

  assign operand  = ACC_WIDTH'($signed(in_data));
  assign beat_ovf = c_msb_in ^ c_out;
  assign cnt_inc  = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);

  ripple_carry_adder #(.WIDTH(ACC_WIDTH)) u_add (
    .a            (acc_q),
    .b            (operand),
    .carry_in     (1'b0),
    .sum          (sum),
    .carry_msb_in (c_msb_in),
    .carry_out    (c_out)
  );

  // Next-state: drain result, then fold in an accepted beat (last beat reloads output).
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_d      = ovf_q;
    out_data_d = out_data_q;
    out_cnt_d  = out_cnt_q;
    out_ovf_d  = out_ovf_q;
    if (fire_out) state_d = ACCUM;
    if (fire_in) begin
      if (in_last) begin
        out_data_d = sacc_t'(sum);
        out_cnt_d  = cnt_inc;
        out_ovf_d  = ovf_q | beat_ovf;
        acc_d      = '0;
        cnt_d      = '0;
        ovf_d      = 1'b0;
        state_d    = HOLD;
      end else begin
        acc_d = sacc_t'(sum);
        cnt_d = cnt_inc;
        ovf_d = ovf_q | beat_ovf;
      end
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ACCUM;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      out_data_q <= '0;
      out_cnt_q  <= '0;
      out_ovf_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      out_data_q <= out_data_d;
      out_cnt_q  <= out_cnt_d;
      out_ovf_q  <= out_ovf_d;
    end
  end

endmodule

// File: tb/tb_stream_accumulator.sv
// Bench: two widths (20 and 10) driven by one stream, checked against an integer model.
module tb_stream_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_last, out_ready;
  logic [7:0]  in_data;
  logic        in_ready20, in_ready10, out_valid20, out_valid10;
  logic [19:0] out_data20;
  logic [9:0]  out_data10;
  logic [7:0]  out_count20, out_count10;
  logic        out_ovf20, out_ovf10;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  stream_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(20), .CNT_WIDTH(8)) u_dut20 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready20),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid20),
    .out_ready(out_ready), .out_data(out_data20), .out_count(out_count20),
    .out_ovf(out_ovf20)
  );

  stream_accumulator #(.DATA_WIDTH(8), .ACC_WIDTH(10), .CNT_WIDTH(8)) u_dut10 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready10),
    .in_data(in_data), .in_last(in_last), .out_valid(out_valid10),
    .out_ready(out_ready), .out_data(out_data10), .out_count(out_count10),
    .out_ovf(out_ovf10)
  );

  task automatic chk(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int     W [2] = '{20, 10};
  longint m_acc [2], m_od [2];
  bit     m_ovf [2], m_oovf [2];
  int     m_cnt, m_ocnt;
  bit     m_vld;

  function automatic longint wrapw(input longint v, input int w);
    longint m, r;
    m = longint'(1) << w;
    r = ((v % m) + m) % m;
    if (r >= m / 2) r = r - m;
    return r;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    bit     rdy;
    longint s, lo, hi;
    bit     bo;
    int     ncnt;
    if (!rst_n) begin
      for (int i = 0; i < 2; i++) begin
        m_acc[i] = 0; m_od[i] = 0; m_ovf[i] = 0; m_oovf[i] = 0;
      end
      m_cnt = 0; m_ocnt = 0; m_vld = 0;
    end else begin
      rdy = !m_vld || out_ready;
      if (m_vld && out_ready) m_vld = 0;
      if (in_valid && rdy) begin
        ncnt = (m_cnt == 255) ? 255 : m_cnt + 1;
        for (int i = 0; i < 2; i++) begin
          hi = (longint'(1) << (W[i] - 1)) - 1;
          lo = -(longint'(1) << (W[i] - 1));
          s  = m_acc[i] + longint'($signed(in_data));
          bo = (s > hi) || (s < lo);
          s  = wrapw(s, W[i]);
          if (in_last) begin
            m_od[i] = s; m_oovf[i] = m_ovf[i] | bo; m_acc[i] = 0; m_ovf[i] = 0;
          end else begin
            m_acc[i] = s; m_ovf[i] = m_ovf[i] | bo;
          end
        end
        if (in_last) begin
          m_ocnt = ncnt; m_cnt = 0; m_vld = 1;
        end else begin
          m_cnt = ncnt;
        end
      end
    end
  end

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    chk("in_ready20", in_ready20, !m_vld || out_ready);
    chk("in_ready10", in_ready10, !m_vld || out_ready);
    chk("out_valid20", out_valid20, m_vld);
    chk("out_valid10", out_valid10, m_vld);
    if (m_vld || !rst_n) begin
      chk("data20", longint'($signed(out_data20)), m_od[0]);
      chk("data10", longint'($signed(out_data10)), m_od[1]);
      chk("count20", out_count20, m_ocnt);
      chk("count10", out_count10, m_ocnt);
      chk("ovf20", out_ovf20, m_oovf[0]);
      chk("ovf10", out_ovf10, m_oovf[1]);
    end
  end

  // ---------------- stimulus ----------------
  task automatic beat(input int d, input bit last);
    bit r;
    int n;
    n = 0;
    r = 0;
    in_valid = 1'b1; in_data = d[7:0]; in_last = last;
    while (!r && n < 50) begin
      @(negedge clk); r = in_ready20;
      @(posedge clk); #1;
      n++;
    end
    if (!r) chk("beat_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("lit_rst_valid", out_valid20, 0);
    chk("lit_rst_data", out_data20, 0);
    chk("lit_rst_count", out_count20, 0);
    chk("lit_rst_ovf", out_ovf20, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    idle(1);

    // 3, -5, 10 -> 8, one-cycle valid pulse
    beat(3, 0); beat(-5, 0); beat(10, 1);
    @(negedge clk);
    chk("lit_sum3_valid", out_valid20, 1);
    chk("lit_sum3_data", longint'($signed(out_data20)), 8);
    chk("lit_sum3_count", out_count20, 3);
    chk("lit_sum3_ovf", out_ovf20, 0);
    @(negedge clk);
    chk("lit_sum3_pulse", out_valid20, 0);
    @(posedge clk); #1;

    // single-beat -128
    beat(-128, 1);
    @(negedge clk);
    chk("lit_neg_data", out_data20, 'hFFF80);
    chk("lit_neg_count", out_count20, 1);
    @(posedge clk); #1;

    // overflow at width 10, sticky flag must not leak
    repeat (4) beat(127, 0);
    beat(127, 1);
    @(negedge clk);
    chk("lit_wrap10_data", longint'($signed(out_data10)), -389);
    chk("lit_wrap10_ovf", out_ovf10, 1);
    chk("lit_wide20_data", longint'($signed(out_data20)), 635);
    chk("lit_wide20_ovf", out_ovf20, 0);
    @(posedge clk); #1;
    beat(1, 0); beat(1, 1);
    @(negedge clk);
    chk("lit_noleak_data", longint'($signed(out_data10)), 2);
    chk("lit_noleak_ovf", out_ovf10, 0);
    @(posedge clk); #1;

    // backpressure with junk offered during the stall
    out_ready = 1'b0;
    beat(1, 0); beat(2, 1);
    in_valid = 1'b1; in_data = 8'd99; in_last = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("lit_bp_ready", in_ready20, 0);
      chk("lit_bp_valid", out_valid20, 1);
      chk("lit_bp_data", out_data20, 3);
    end
    @(posedge clk); #1;
    out_ready = 1'b1; in_data = 8'd7; in_last = 1'b1;
    @(negedge clk);
    chk("lit_rel_ready", in_ready20, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit_rel_valid", out_valid20, 1);
    chk("lit_rel_data", out_data20, 7);
    chk("lit_rel_count", out_count20, 1);
    @(posedge clk); #1;

    // gapped input
    beat(4, 0); idle(2); beat(4, 0); idle(2); beat(4, 1);
    @(negedge clk);
    chk("lit_gap_data", out_data20, 12);
    chk("lit_gap_count", out_count20, 3);
    @(posedge clk); #1;

    // reset mid-packet
    beat(5, 0); beat(6, 0);
    rst_n = 1'b0;
    @(negedge clk);
    chk("lit_midrst_valid", out_valid20, 0);
    @(posedge clk); #1; rst_n = 1'b1;
    beat(1, 1);
    @(negedge clk);
    chk("lit_midrst_data", out_data20, 1);
    chk("lit_midrst_count", out_count20, 1);
    @(posedge clk); #1;

    // count saturation
    repeat (299) beat(1, 0);
    beat(1, 1);
    @(negedge clk);
    chk("lit_sat_count", out_count20, 255);
    chk("lit_sat_data", out_data20, 300);
    @(posedge clk); #1;

    // randomized traffic
    for (int c = 0; c < 3000; c++) begin
      in_valid  = ($urandom_range(0, 9) < 7);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(0, 4) == 0);
      out_ready = ($urandom_range(0, 9) < 7);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    idle(3);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
